alu_result_fifo: RTL and testbench

Buffers results from the 8-bit ALU `top` (`y`, `parity`, `overflow`, `greater`, `is_eq`, `less`) in a small synchronous FIFO with a valid/ready handshake, so the consumer can stall without losing results. The block also keeps overflow statistics for software. It sits directly downstream of the ALU, which is purely combinational. The ALU's operands are held stable by the issuing stage while `in_valid` is high.

---
 rtl/alu_result_fifo.sv | 66 ++++++
 tb/tb_alu_result_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word fall-through FIFO for ALU results with overflow statistics.
// Define ALU_PARITY_CHECK_EN to build the sticky parity checker on pushed results.
module alu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [7:0]                 y,
   input  logic                       parity,
   input  logic                       overflow,
   input  logic                       greater,
   input  logic                       is_eq,
   input  logic                       less,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [12:0]                out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [CNT_W-1:0]           ovf_cnt,
   output logic                       ovf_seen,
   input  logic                       clr_stats,
   output logic                       parity_err
);
   localparam int AW = $clog2(DEPTH);
   logic [12:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        push, pop, full, empty;
   assign empty     = wr_ptr == rd_ptr;
   assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = mem[rd_ptr[AW-1:0]];
   assign count     = wr_ptr - rd_ptr;
   // storage is deliberately left out of reset
   always_ff @(posedge clk)
      if (push) mem[wr_ptr[AW-1:0]] <= {less, is_eq, greater, overflow, parity, y};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ovf_cnt  <= '0;
         ovf_seen <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (clr_stats) begin
            ovf_cnt  <= '0;
            ovf_seen <= 1'b0;
         end else if (push && overflow) begin
            ovf_cnt  <= &ovf_cnt ? ovf_cnt : ovf_cnt + 1'b1;
            ovf_seen <= 1'b1;
         end
      end
`ifdef ALU_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) parity_err <= 1'b0;
      else if (clr_stats) parity_err <= 1'b0;
      else if (push && ((^y) != parity)) parity_err <= 1'b1;
`else
   assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: directed checks of alu_result_fifo ordering, handshake, stats and reset.
module tb_alu_result_fifo;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, clr_stats = 1'b0;
   logic [7:0]  y = '0;
   logic        parity = 1'b0, overflow = 1'b0, greater = 1'b0, is_eq = 1'b0, less = 1'b0;
   logic [12:0] out_data;
   logic [2:0]  count;
   logic [7:0]  ovf_cnt;
   logic        ovf_seen, parity_err;
   int          checks = 0, errors = 0;
   logic        perr_exp;

   alu_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .y(y),
      .parity(parity), .overflow(overflow), .greater(greater), .is_eq(is_eq), .less(less),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
      .ovf_cnt(ovf_cnt), .ovf_seen(ovf_seen), .clr_stats(clr_stats), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [7:0] v, input logic ov);
      y = v; parity = ^v; less = v[0]; is_eq = v[1]; greater = v[2]; overflow = ov;
   endtask

   function automatic logic [12:0] ent(input logic [7:0] v, input logic ov);
      return {v[0], v[1], v[2], ov, ^v, v};
   endfunction

   initial begin
      #12;
      @(negedge clk) rst_n = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      chk("rst_ovf_seen", ovf_seen, 0);
      chk("rst_parity_err", parity_err, 0);
      for (int i = 0; i < 10; i++) begin
         tick;
         chk("idle_count", count, 0);
         chk("idle_out_valid", out_valid, 0);
      end
      // fill to full with the consumer stalled
      in_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(8'(i * 8'h11), 1'b0);
         tick;
      end
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
      drive(8'h55, 1'b0);
      tick;
      chk("full_reject_count", count, 4);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, ent(8'(i * 8'h11), 1'b0));
         tick;
      end
      chk("drain_count", count, 0);
      chk("drain_out_valid", out_valid, 0);
      // streaming push+pop each cycle
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         drive(8'(k), 1'b0);
         if (k > 0) begin
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, ent(8'(k - 1), 1'b0));
            chk("stream_count", count, 1);
         end
         tick;
      end
      in_valid = 1'b0;
      chk("stream_last", out_data, ent(8'd19, 1'b0));
      tick;
      chk("stream_end_count", count, 0);
      // overflow statistics
      in_valid = 1'b1;
      drive(8'h80, 1'b1);
      for (int i = 0; i < 10; i++) tick;
      chk("ovf_cnt_10", ovf_cnt, 10);
      chk("ovf_seen_set", ovf_seen, 1);
      for (int i = 10; i < 300; i++) tick;
      chk("ovf_cnt_sat", ovf_cnt, 255);
      chk("ovf_seen_sat", ovf_seen, 1);
      chk("ovf_stream_data", out_data, ent(8'h80, 1'b1));
      clr_stats = 1'b1;
      tick;
      clr_stats = 1'b0;
      in_valid = 1'b0;
      chk("clr_ovf_cnt", ovf_cnt, 0);
      chk("clr_ovf_seen", ovf_seen, 0);
      chk("clr_keeps_fifo", count, 1);
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      chk("ovf_cnt_after_clr", ovf_cnt, 1);
      tick;
      chk("ovf_drained", count, 0);
      // parity checker
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive(8'h03, 1'b0);
      parity = 1'b0;
      tick;
      in_valid = 1'b0;
      chk("parity_ok", parity_err, 0);
`ifdef ALU_PARITY_CHECK_EN
      perr_exp = 1'b1;
`else
      perr_exp = 1'b0;
`endif
      in_valid = 1'b1;
      drive(8'h07, 1'b0);
      parity = 1'b0;
      tick;
      in_valid = 1'b0;
      chk("parity_bad", parity_err, 32'(perr_exp));
      chk("parity_stored", out_data, {3'b110, 2'b00, 8'h03});
      clr_stats = 1'b1;
      tick;
      clr_stats = 1'b0;
      chk("parity_clr", parity_err, 0);
      chk("parity_count", count, 2);
      // async reset with 3 entries held
      in_valid = 1'b1;
      drive(8'hA5, 1'b0);
      tick;
      in_valid = 1'b0;
      chk("pre_rst_count", count, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_count", count, 0);
      chk("async_rst_ready", in_ready, 1);
      @(negedge clk) rst_n = 1'b1;
      tick;
      chk("post_rst_count", count, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
